// File: rtl/id_stage_pipe.sv
// Pipelined instruction-decode stage: register file with write-back bypass, load-use
// hazard detection, in-decode branch/jump resolution and a registered ID/EX bundle.
module id_stage_pipe #(
   parameter int NREG     = 32,
   parameter int BYPASS   = 1,
   parameter int BR_IN_ID = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_instr,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        ex_load,
   input  logic [4:0]  ex_load_rd,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  out_alu_op,
   output logic        out_bse,
   output logic [5:0]  out_funct,
   output logic [4:0]  out_shamt,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [31:0] out_se,
   output logic [4:0]  out_rd,
   output logic        out_mem_rd,
   output logic        out_mem_wr,
   output logic        out_reg_wr,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef struct packed {
      logic [2:0]  alu_op;
      logic        bse;
      logic [5:0]  funct;
      logic [4:0]  shamt;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] se;
      logic [4:0]  rd;
      logic        mem_rd;
      logic        mem_wr;
      logic        reg_wr;
   } bundle_t;

   logic [31:0] rf_q [NREG];
   bundle_t     bundle_d, bundle_q;
   logic        valid_d, valid_q;
   logic        redir_d, redir_q;
   logic [31:0] rpc_q;

   logic [5:0]  opcode;
   logic [4:0]  rs, rt;
   logic [31:0] op_a, op_b, se, br_target, j_target, target;
   logic        taken, uses_rt, haz, transfer, rf_we;

   // Indices beyond the implemented register count read as zero and are never written.
   function automatic logic reg_ok(input logic [4:0] idx);
      return 32'(idx) < 32'(NREG);
   endfunction

   function automatic logic [31:0] read_reg(input logic [4:0] idx);
      if (idx == 5'd0 || !reg_ok(idx))
         return 32'd0;
      else if (BYPASS != 0 && wb_en && wb_rd == idx)
         return wb_data;
      else
         return rf_q[idx[RW-1:0]];
   endfunction

   assign opcode    = in_instr[31:26];
   assign rs        = in_instr[25:21];
   assign rt        = in_instr[20:16];
   assign op_a      = read_reg(rs);
   assign op_b      = read_reg(rt);
   assign se        = {{16{in_instr[15]}}, in_instr[15:0]};
   assign br_target = in_pc + {se[29:0], 2'b00};
   assign j_target  = {in_pc[31:28], in_instr[25:0], 2'b00};

   assign uses_rt  = (opcode == OP_RTYPE) || (opcode == OP_SW) ||
                     (opcode == OP_BEQ)   || (opcode == OP_BNE);
   assign haz      = ex_load && (ex_load_rd != 5'd0) &&
                     ((ex_load_rd == rs) || (uses_rt && ex_load_rd == rt));
   assign in_ready = !rst && !haz && (!valid_q || out_ready);
   assign transfer = in_valid && in_ready && !flush;
   assign rf_we    = wb_en && (wb_rd != 5'd0) && reg_ok(wb_rd);

   always_comb begin
      bundle_d        = '0;
      bundle_d.funct  = in_instr[5:0];
      bundle_d.shamt  = in_instr[10:6];
      bundle_d.a      = op_a;
      bundle_d.b      = op_b;
      bundle_d.se     = se;
      bundle_d.rd     = (opcode == OP_RTYPE) ? in_instr[15:11] : rt;
      taken           = 1'b0;
      target          = br_target;
      case (opcode)
         OP_RTYPE: begin bundle_d.alu_op = 3'b010; bundle_d.reg_wr = 1'b1; end
         OP_ADDI:  begin bundle_d.bse = 1'b1; bundle_d.reg_wr = 1'b1; end
         OP_LW:    begin bundle_d.bse = 1'b1; bundle_d.mem_rd = 1'b1; bundle_d.reg_wr = 1'b1; end
         OP_SW:    begin bundle_d.bse = 1'b1; bundle_d.mem_wr = 1'b1; end
         OP_BEQ:   begin bundle_d.alu_op = 3'b001; taken = (op_a == op_b); end
         OP_BNE:   begin bundle_d.alu_op = 3'b001; taken = (op_a != op_b); end
         OP_J:     begin taken = 1'b1; target = j_target; end
         default:  ;
      endcase
   end

   // Flush wins over everything; a held bundle only retires when EX takes it.
   always_comb begin
      if (flush)          valid_d = 1'b0;
      else if (transfer)  valid_d = 1'b1;
      else if (out_ready) valid_d = 1'b0;
      else                valid_d = valid_q;
   end

   assign redir_d = (BR_IN_ID != 0) && transfer && taken;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         bundle_q <= '0;
         redir_q  <= 1'b0;
         rpc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         redir_q <= redir_d;
         if (transfer) bundle_q <= bundle_d;
         if (redir_d)  rpc_q    <= target;
      end
   end

   // NOTE: the register array is deliberately reset, since architectural state
   // must read zero after reset; this rules out a plain RAM macro.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (rf_we) begin
         rf_q[wb_rd[RW-1:0]] <= wb_data;
      end
   end

   assign out_valid      = valid_q;
   assign out_alu_op     = bundle_q.alu_op;
   assign out_bse        = bundle_q.bse;
   assign out_funct      = bundle_q.funct;
   assign out_shamt      = bundle_q.shamt;
   assign out_a          = bundle_q.a;
   assign out_b          = bundle_q.b;
   assign out_se         = bundle_q.se;
   assign out_rd         = bundle_q.rd;
   assign out_mem_rd     = bundle_q.mem_rd;
   assign out_mem_wr     = bundle_q.mem_wr;
   assign out_reg_wr     = bundle_q.reg_wr;
   assign redirect_valid = redir_q;
   assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: three configurations (default, BYPASS=0, NREG=16) share one
// stimulus stream; directed scenarios plus random traffic against a behavioural model.
module tb_id_stage_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, wb_en, ex_load, flush, out_ready;
   logic [31:0] in_pc, in_instr, wb_data;
   logic [4:0]  wb_rd, ex_load_rd;

   typedef struct packed {
      logic [2:0]  alu_op;
      logic        bse;
      logic [5:0]  funct;
      logic [4:0]  shamt;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] se;
      logic [4:0]  rd;
      logic        mem_rd;
      logic        mem_wr;
      logic        reg_wr;
   } bundle_t;

   bundle_t     o_b     [3];
   logic        o_valid [3];
   logic        o_rv    [3];
   logic        o_ready [3];
   logic [31:0] o_rpc   [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [2:0]  alu_op;
      logic [5:0]  funct;
      logic [4:0]  shamt, rd;
      logic [31:0] a, b, se, rpc;
      logic        bse, mem_rd, mem_wr, reg_wr, valid, rv, ready;
      id_stage_pipe #(.NREG(g == 2 ? 16 : 32), .BYPASS(g == 1 ? 0 : 1), .BR_IN_ID(1)) dut (
         .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready), .in_pc(in_pc),
         .in_instr(in_instr), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
         .ex_load(ex_load), .ex_load_rd(ex_load_rd), .flush(flush), .out_valid(valid),
         .out_ready(out_ready), .out_alu_op(alu_op), .out_bse(bse), .out_funct(funct),
         .out_shamt(shamt), .out_a(a), .out_b(b), .out_se(se), .out_rd(rd),
         .out_mem_rd(mem_rd), .out_mem_wr(mem_wr), .out_reg_wr(reg_wr),
         .redirect_valid(rv), .redirect_pc(rpc));
      assign o_b[g]     = {alu_op, bse, funct, shamt, a, b, se, rd, mem_rd, mem_wr, reg_wr};
      assign o_valid[g] = valid;
      assign o_rv[g]    = rv;
      assign o_ready[g] = ready;
      assign o_rpc[g]   = rpc;
   end

   int checks = 0;
   int errors = 0;

   // Behavioural model state, one slot per configuration.
   logic [31:0] m_rf    [3][32];
   logic        m_valid [3];
   bundle_t     m_b     [3];
   logic        m_rv    [3];
   logic [31:0] m_rpc   [3];

   function automatic int nreg_of(int c);
      return (c == 2) ? 16 : 32;
   endfunction

   function automatic logic [31:0] m_read(int c, logic [4:0] idx);
      if (idx == 0 || int'(idx) >= nreg_of(c)) return 32'd0;
      if (c != 1 && wb_en && wb_rd == idx) return wb_data;
      return m_rf[c][idx];
   endfunction

   function automatic bundle_t m_decode(int c, logic [31:0] ins);
      bundle_t    b;
      logic [5:0] op;
      op       = ins[31:26];
      b        = '0;
      b.funct  = ins[5:0];
      b.shamt  = ins[10:6];
      b.a      = m_read(c, ins[25:21]);
      b.b      = m_read(c, ins[20:16]);
      b.se     = int'($signed(ins[15:0]));
      b.rd     = (op == 6'h00) ? ins[15:11] : ins[20:16];
      case (op)
         6'h00: begin b.alu_op = 3'b010; b.reg_wr = 1; end
         6'h08: begin b.bse = 1; b.reg_wr = 1; end
         6'h23: begin b.bse = 1; b.mem_rd = 1; b.reg_wr = 1; end
         6'h2B: begin b.bse = 1; b.mem_wr = 1; end
         6'h04, 6'h05: b.alu_op = 3'b001;
         default: ;
      endcase
      return b;
   endfunction

   function automatic bit m_taken(int c, logic [31:0] ins);
      logic [31:0] a, b;
      a = m_read(c, ins[25:21]);
      b = m_read(c, ins[20:16]);
      case (ins[31:26])
         6'h04:   return a == b;
         6'h05:   return a != b;
         6'h02:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] m_target(logic [31:0] ins, logic [31:0] pc);
      if (ins[31:26] == 6'h02)
         return (pc & 32'hF000_0000) | (32'(ins[25:0]) * 4);
      return pc + 32'(4 * int'($signed(ins[15:0])));
   endfunction

   function automatic bit m_ready();
      logic [5:0] op;
      logic [4:0] rs, rt;
      bit         uses_rt, haz;
      op      = in_instr[31:26];
      rs      = in_instr[25:21];
      rt      = in_instr[20:16];
      uses_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
      haz     = ex_load && ex_load_rd != 0 && (ex_load_rd == rs || (uses_rt && ex_load_rd == rt));
      return !rst && !haz && (!m_valid[0] || out_ready);
   endfunction

   // Advance the model with the current inputs, then one clock; outputs are stable on return.
   task automatic tick();
      bit xfer;
      xfer = in_valid && m_ready() && !flush;
      for (int c = 0; c < 3; c++) begin
         if (rst) begin
            m_valid[c] = 0; m_b[c] = '0; m_rv[c] = 0; m_rpc[c] = 0;
            for (int r = 0; r < 32; r++) m_rf[c][r] = 0;
         end else begin
            if (xfer) begin
               m_b[c]     = m_decode(c, in_instr);
               m_rv[c]    = m_taken(c, in_instr);
               if (m_rv[c]) m_rpc[c] = m_target(in_instr, in_pc);
               m_valid[c] = 1;
            end else begin
               m_rv[c] = 0;
               if (flush || out_ready) m_valid[c] = 0;
            end
            if (wb_en && wb_rd != 0 && int'(wb_rd) < nreg_of(c)) m_rf[c][wb_rd] = wb_data;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      rst = 0; in_valid = 0; in_pc = 0; in_instr = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
      ex_load = 0; ex_load_rd = 0; flush = 0; out_ready = 1;
   endtask

   function automatic logic [31:0] enc_r(logic [4:0] rs, rt, rd);
      return {6'h00, rs, rt, rd, 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, rt, logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic test_reset();
      set_idle();
      rst = 1; in_valid = 1; in_instr = enc_r(1, 2, 3);
      #1;
      checks++; if (o_ready[0] !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", o_ready[0]); end
      tick();
      checks++; if (o_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", o_valid[0]); end
      checks++; if (o_rv[0] !== 1'b0) begin errors++; $display("FAIL reset_redirect_valid: got %0b want 0", o_rv[0]); end
      checks++; if (o_b[0] !== '0) begin errors++; $display("FAIL reset_bundle: got %h want 0", o_b[0]); end
      checks++; if (o_rpc[0] !== 32'd0) begin errors++; $display("FAIL reset_redirect_pc: got %h want 0", o_rpc[0]); end
   endtask

   task automatic test_reset_midstream();
      set_idle();
      wb_en = 1; wb_rd = 5; wb_data = 32'h55; in_valid = 1; in_instr = enc_r(5, 0, 6);
      tick();
      wb_en = 0;
      checks++; if (o_valid[0] !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %0b want 1", o_valid[0]); end
      rst = 1;
      #1;
      checks++; if (o_ready[0] !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %0b want 0", o_ready[0]); end
      tick();
      checks++; if (o_valid[0] !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %0b want 0", o_valid[0]); end
      checks++; if (o_rv[0] !== 1'b0) begin errors++; $display("FAIL mid_redirect: got %0b want 0", o_rv[0]); end
      rst = 0;
      tick();
      checks++; if (o_valid[0] !== 1'b1) begin errors++; $display("FAIL mid_post_valid: got %0b want 1", o_valid[0]); end
      checks++; if (o_b[0].a !== 32'd0) begin errors++; $display("FAIL mid_r5_cleared: got %h want 0", o_b[0].a); end
   endtask

   task automatic test_bypass();
      set_idle();
      wb_en = 1; wb_rd = 3; wb_data = 32'h1111_1111;
      tick();
      wb_data = 32'hDEAD_BEEF; in_valid = 1; in_instr = enc_r(3, 0, 4);
      tick();
      checks++; if (o_b[0].a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_on: got %h want deadbeef", o_b[0].a); end
      checks++; if (o_b[1].a !== 32'h1111_1111) begin errors++; $display("FAIL bypass_off: got %h want 11111111", o_b[1].a); end
      checks++; if (o_b[0].rd !== 5'd4 || o_b[0].alu_op !== 3'b010 || o_b[0].reg_wr !== 1'b1 || o_b[0].bse !== 1'b0)
         begin errors++; $display("FAIL rtype_ctrl: got rd=%0d alu=%b wr=%b bse=%b want 4 010 1 0",
                                  o_b[0].rd, o_b[0].alu_op, o_b[0].reg_wr, o_b[0].bse); end
      set_idle();
      tick();
   endtask

   task automatic test_load_use();
      set_idle();
      ex_load = 1; ex_load_rd = 2; in_valid = 1; in_instr = enc_r(2, 0, 1);
      #1;
      checks++; if (o_ready[0] !== 1'b0) begin errors++; $display("FAIL lu_stall: got %0b want 0", o_ready[0]); end
      tick();
      checks++; if (o_valid[0] !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %0b want 0", o_valid[0]); end
      ex_load = 0;
      #1;
      checks++; if (o_ready[0] !== 1'b1) begin errors++; $display("FAIL lu_release: got %0b want 1", o_ready[0]); end
      tick();
      checks++; if (o_valid[0] !== 1'b1 || o_b[0].rd !== 5'd1) begin errors++;
         $display("FAIL lu_accept: got valid=%0b rd=%0d want 1 1", o_valid[0], o_b[0].rd); end
      ex_load = 1; ex_load_rd = 2; in_instr = enc_i(6'h08, 1, 2, 16'd5);
      #1;
      checks++; if (o_ready[0] !== 1'b1) begin errors++; $display("FAIL lu_addi_rt: got %0b want 1", o_ready[0]); end
      in_instr = enc_i(6'h2B, 1, 2, 16'd0);
      #1;
      checks++; if (o_ready[0] !== 1'b0) begin errors++; $display("FAIL lu_sw_rt: got %0b want 0", o_ready[0]); end
      ex_load_rd = 0; in_instr = enc_r(0, 0, 1);
      #1;
      checks++; if (o_ready[0] !== 1'b1) begin errors++; $display("FAIL lu_r0: got %0b want 1", o_ready[0]); end
      set_idle();
      tick();
   endtask

   task automatic test_branch();
      set_idle();
      wb_en = 1; wb_rd = 1; wb_data = 32'd7;
      tick();
      set_idle();
      in_valid = 1; in_pc = 32'h100; in_instr = enc_i(6'h04, 1, 1, 16'd4);
      tick();
      checks++; if (o_rv[0] !== 1'b1 || o_rpc[0] !== 32'h110) begin errors++;
         $display("FAIL beq_taken: got v=%0b pc=%h want 1 00000110", o_rv[0], o_rpc[0]); end
      checks++; if (o_b[0].alu_op !== 3'b001 || o_b[0].reg_wr !== 1'b0) begin errors++;
         $display("FAIL beq_ctrl: got alu=%b wr=%b want 001 0", o_b[0].alu_op, o_b[0].reg_wr); end
      in_valid = 0;
      tick();
      checks++; if (o_rv[0] !== 1'b0) begin errors++; $display("FAIL redirect_one_cycle: got %0b want 0", o_rv[0]); end
      in_valid = 1; in_instr = enc_i(6'h05, 1, 1, 16'd4);
      tick();
      checks++; if (o_rv[0] !== 1'b0 || o_valid[0] !== 1'b1) begin errors++;
         $display("FAIL bne_not_taken: got rv=%0b valid=%0b want 0 1", o_rv[0], o_valid[0]); end
      in_pc = 32'h4; in_instr = enc_i(6'h04, 0, 0, 16'hFFFE);
      tick();
      checks++; if (o_rv[0] !== 1'b1 || o_rpc[0] !== 32'hFFFF_FFFC) begin errors++;
         $display("FAIL beq_wrap: got v=%0b pc=%h want 1 fffffffc", o_rv[0], o_rpc[0]); end
      set_idle();
      tick();
   endtask

   task automatic test_jump_backpressure();
      bundle_t exp_j;
      set_idle();
      in_valid = 1; in_pc = 32'h8000_0004; in_instr = {6'h02, 26'h40};
      exp_j = m_decode(0, in_instr);
      tick();
      checks++; if (o_rv[0] !== 1'b1 || o_rpc[0] !== 32'h8000_0100) begin errors++;
         $display("FAIL jump: got v=%0b pc=%h want 1 80000100", o_rv[0], o_rpc[0]); end
      out_ready = 0; in_instr = enc_i(6'h08, 0, 9, 16'h0010);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (o_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, o_ready[0]); end
         tick();
         checks++; if (o_valid[0] !== 1'b1 || o_b[0] !== exp_j || o_rv[0] !== 1'b0) begin errors++;
            $display("FAIL bp_hold[%0d]: got v=%0b rv=%0b b=%h want 1 0 %h", i, o_valid[0], o_rv[0], o_b[0], exp_j); end
      end
      out_ready = 1;
      tick();
      checks++; if (o_valid[0] !== 1'b1 || o_b[0].bse !== 1'b1 || o_b[0].rd !== 5'd9) begin errors++;
         $display("FAIL bp_resume: got v=%0b bse=%0b rd=%0d want 1 1 9", o_valid[0], o_b[0].bse, o_b[0].rd); end
      set_idle();
      tick();
   endtask

   task automatic test_flush();
      set_idle();
      in_valid = 1; in_instr = enc_i(6'h08, 0, 1, 16'd1);
      tick();
      flush = 1; out_ready = 0; in_instr = enc_i(6'h04, 0, 0, 16'd4);
      tick();
      checks++; if (o_valid[0] !== 1'b0 || o_rv[0] !== 1'b0) begin errors++;
         $display("FAIL flush: got valid=%0b rv=%0b want 0 0", o_valid[0], o_rv[0]); end
      set_idle();
      tick();
   endtask

   task automatic test_nreg();
      set_idle();
      wb_en = 1; wb_rd = 20; wb_data = 32'h1234_5678;
      tick();
      set_idle();
      in_valid = 1; in_instr = enc_r(20, 0, 7);
      tick();
      checks++; if (o_b[2].a !== 32'd0) begin errors++; $display("FAIL nreg16_r20: got %h want 0", o_b[2].a); end
      checks++; if (o_b[0].a !== 32'h1234_5678) begin errors++; $display("FAIL nreg32_r20: got %h want 12345678", o_b[0].a); end
      set_idle();
      tick();
   endtask

   task automatic test_random();
      logic [5:0]  ops [8];
      logic [31:0] r;
      ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
      for (int i = 0; i < 3000; i++) begin
         r          = $urandom();
         rst        = ($urandom_range(99) == 0);
         in_valid   = ($urandom_range(9) < 8);
         in_instr   = {ops[$urandom_range(7)], r[25:0]};
         if ($urandom_range(1) == 1) in_instr[25:21] = 5'($urandom_range(3));
         if ($urandom_range(1) == 1) in_instr[20:16] = 5'($urandom_range(3));
         if ($urandom_range(7) == 0) in_instr[15:0] = 16'hFFF0;
         in_pc      = $urandom();
         wb_en      = ($urandom_range(1) == 1);
         wb_rd      = ($urandom_range(1) == 1) ? 5'($urandom_range(3)) : 5'($urandom_range(31));
         wb_data    = $urandom();
         ex_load    = ($urandom_range(3) == 0);
         ex_load_rd = 5'($urandom_range(3));
         flush      = ($urandom_range(15) == 0);
         out_ready  = ($urandom_range(3) != 0);
         #1;
         for (int c = 0; c < 3; c++) begin
            checks++; if (o_ready[c] !== m_ready()) begin errors++;
               $display("FAIL rnd_in_ready cfg%0d cyc%0d: got %0b want %0b", c, i, o_ready[c], m_ready()); end
         end
         tick();
         for (int c = 0; c < 3; c++) begin
            checks++; if (o_valid[c] !== m_valid[c] || o_rv[c] !== m_rv[c]) begin errors++;
               $display("FAIL rnd_valid cfg%0d cyc%0d: got v=%0b rv=%0b want %0b %0b", c, i, o_valid[c], o_rv[c], m_valid[c], m_rv[c]); end
            if (m_valid[c]) begin
               checks++; if (o_b[c] !== m_b[c]) begin errors++;
                  $display("FAIL rnd_bundle cfg%0d cyc%0d: got %h want %h", c, i, o_b[c], m_b[c]); end
            end
            if (m_rv[c]) begin
               checks++; if (o_rpc[c] !== m_rpc[c]) begin errors++;
                  $display("FAIL rnd_redirect_pc cfg%0d cyc%0d: got %h want %h", c, i, o_rpc[c], m_rpc[c]); end
            end
         end
      end
      set_idle();
      tick();
   endtask

   initial begin
      set_idle();
      test_reset();
      test_reset_midstream();
      test_bypass();
      test_load_use();
      test_branch();
      test_jump_backpressure();
      test_flush();
      test_nreg();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
